// File: rtl/add_xfer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : add_xfer_ctrl
//  Purpose  : Vector-add transfer controller. For each element it reads
//             operand A and operand B from a synchronous-read memory, hands
//             them to an external combinational adder through DOut1/DOut2
//             and writes the adder result back to the destination vector.
//             Four cycles per element; one-cycle done pulse at the end.
//  Revision : 1.0 - initial release
// ============================================================================
module add_xfer_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_a,
  input  logic [ADDR_W-1:0] src_b,
  input  logic [ADDR_W-1:0] dst,
  input  logic [7:0]        len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        mem_wdata,
  output logic [7:0]        DOut1,
  output logic [7:0]        DOut2,
  input  logic [7:0]        ADDOut
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_A  = 3'd1,
    S_RD_B  = 3'd2,
    S_LAT_B = 3'd3,
    S_WR    = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] src_a_q;
  logic [ADDR_W-1:0] src_b_q;
  logic [ADDR_W-1:0] dst_q;
  logic [7:0]        len_q;
  logic [7:0]        idx_q;
  logic              busy_q;
  logic              done_q;
  logic              mem_rd_q;
  logic              mem_wr_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [7:0]        dout1_q;
  logic [7:0]        dout2_q;

  // Element addresses; sums wrap naturally at ADDR_W bits.
  logic [7:0]        w_idx_inc;
  logic [ADDR_W-1:0] w_addr_b;
  logic [ADDR_W-1:0] w_addr_d;
  logic [ADDR_W-1:0] w_addr_a_next;
  logic              w_last;

  assign w_idx_inc     = idx_q + 8'd1;
  assign w_addr_b      = src_b_q + ADDR_W'(idx_q);
  assign w_addr_d      = dst_q + ADDR_W'(idx_q);
  assign w_addr_a_next = src_a_q + ADDR_W'(w_idx_inc);
  assign w_last        = (idx_q == (len_q - 8'd1));

  // Sequencer: outputs are registered together with the state they belong
  // to, so each strobe/address is valid during the cycle of its state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      src_a_q    <= '0;
      src_b_q    <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_addr_q <= '0;
      dout1_q    <= '0;
      dout2_q    <= '0;
    end else begin
      // Strobes and address default to idle values each cycle.
      done_q     <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_addr_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            src_a_q <= src_a;
            src_b_q <= src_b;
            dst_q   <= dst;
            len_q   <= len;
            idx_q   <= '0;
            if (len == 8'd0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q    <= S_RD_A;
              busy_q     <= 1'b1;
              mem_rd_q   <= 1'b1;
              mem_addr_q <= src_a;
            end
          end
        end
        S_RD_A: begin
          state_q    <= S_RD_B;
          mem_rd_q   <= 1'b1;
          mem_addr_q <= w_addr_b;
        end
        S_RD_B: begin
          // Operand A arrives this cycle.
          dout1_q <= mem_rdata;
          state_q <= S_LAT_B;
        end
        S_LAT_B: begin
          // Operand B arrives this cycle; next cycle the adder output is final.
          dout2_q    <= mem_rdata;
          state_q    <= S_WR;
          mem_wr_q   <= 1'b1;
          mem_addr_q <= w_addr_d;
        end
        S_WR: begin
          if (w_last) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            idx_q      <= w_idx_inc;
            state_q    <= S_RD_A;
            mem_rd_q   <= 1'b1;
            mem_addr_q <= w_addr_a_next;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign DOut1     = dout1_q;
  assign DOut2     = dout2_q;
  // Adder result is only settled (and only driven out) during the write cycle.
  assign mem_wdata = mem_wr_q ? ADDOut : 8'd0;

endmodule
`default_nettype wire

// File: doc/add_xfer_ctrl.md
ADD_XFER_CTRL -- requirements
Module: add_xfer_ctrl

Interface
REQ-001 Parameter: ADDR_W, default 8, memory address width.
REQ-002 Port: clk  input  1  system clock; all logic on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  request a vector-add transfer; sampled in IDLE only.
REQ-005 Port: src_a  input  ADDR_W  base address of operand vector A.
REQ-006 Port: src_b  input  ADDR_W  base address of operand vector B.
REQ-007 Port: dst  input  ADDR_W  base address of result vector.
REQ-008 Port: len  input  8  element count; 0 = empty transfer.
REQ-009 Port: busy  output  1  high in RD_A, RD_B, LAT_B, WR.
REQ-010 Port: done  output  1  one-cycle completion pulse.
REQ-011 Port: mem_addr  output  ADDR_W  memory address.
REQ-012 Port: mem_rd  output  1  read strobe; data valid on mem_rdata the following cycle.
REQ-013 Port: mem_wr  output  1  write strobe; memory writes mem_wdata at mem_addr on that edge.
REQ-014 Port: mem_rdata  input  8  read data.
REQ-015 Port: mem_wdata  output  8  write data.
REQ-016 Port: DOut1  output  8  registered operand A to the external combinational adder.
REQ-017 Port: DOut2  output  8  registered operand B to the external combinational adder.
REQ-018 Port: ADDOut  input  8  adder sum, DOut1+DOut2 mod 256.

Function
REQ-019 FSM states SHALL be IDLE, RD_A, RD_B, LAT_B, WR, DONE.
REQ-020 IDLE: on start=1, latch src_a, src_b, dst, len into internal registers, clear index idx to 0; go to DONE if len==0, else RD_A.
REQ-021 RD_A: mem_rd=1, mem_addr=src_a+idx; next RD_B.
REQ-022 RD_B: mem_rd=1, mem_addr=src_b+idx; capture mem_rdata into DOut1 at end of cycle; next LAT_B.
REQ-023 LAT_B: mem_rd=0, mem_wr=0; capture mem_rdata into DOut2 at end of cycle; next WR.
REQ-024 WR: mem_wr=1, mem_addr=dst+idx, mem_wdata=ADDOut; if idx==len_latched-1 go to DONE, else idx<=idx+1 and go to RD_A.
REQ-025 DONE: done=1 for exactly one cycle, busy=0; next IDLE; start ignored in DONE.
REQ-026 Throughput SHALL be 4 cycles per element; start-to-done latency = 4*len+1 cycles (len>0), 1 cycle (len==0).
REQ-027 Address sums SHALL wrap modulo 2^ADDR_W; data sums wrap modulo 256 (no carry out).
REQ-028 start and input-bus changes while busy or in DONE SHALL be ignored; latched values govern the transfer.
REQ-029 mem_rd and mem_wr SHALL never be high in the same cycle; mem_addr=0 and mem_wdata=0 whenever neither strobe is high.
REQ-030 mem_wdata SHALL equal ADDOut only in WR; the block imposes no combinational path from mem_rdata to any output.
REQ-031 len=255 SHALL process 255 elements; idx SHALL be 8 bits.

Reset
REQ-032 rst=1 at a rising edge SHALL force state IDLE and busy, done, mem_rd, mem_wr, mem_addr, mem_wdata, DOut1, DOut2, idx and all latched registers to 0.
REQ-033 rst SHALL take priority over start and over any in-progress transfer; an element interrupted before its WR cycle SHALL NOT be written, and no done pulse SHALL follow.
REQ-034 After rst deasserts, the block SHALL accept start in the first IDLE cycle.

Verification
REQ-035 Single element: mem[0x10]=0x01, mem[0x20]=0x0F, start with src_a=0x10, src_b=0x20, dst=0x30, len=1 -> mem[0x30]=0x10, done pulse 5 cycles after start, busy high exactly 4 cycles.
REQ-036 Vector with overflow: A at 0x00={0x01,0x80,0xFF}, B at 0x40={0x0F,0x80,0x02}, dst=0x80, len=3 -> mem[0x80..0x82]={0x10,0x00,0x01}, done 13 cycles after start.
REQ-037 Address wrap: src_a=0xFE, src_b=0x10, dst=0xFF, len=3 -> reads A from 0xFE,0xFF,0x00; writes to 0xFF,0x00,0x01.
REQ-038 Empty transfer: len=0 -> no mem_rd/mem_wr, done one cycle after start, busy never high.
REQ-039 Ignored start: assert start with new operands during transfer and during DONE -> current results unchanged, no second transfer launched.
REQ-040 Reset mid-operation: assert rst in LAT_B of element 2 of len=4 -> mem[dst+1] unwritten, no done pulse, all outputs 0 next cycle; fresh start then completes normally.
